// File: rtl/rv32i_alu.sv
// rtl/rv32i_alu.sv - RV32I execute-stage integer ALU with registered result
//
// Purpose:
//   Computes add/sub, bitwise logic, shifts, set-less-than and branch compares
//   from two XLEN operands under an encoded opcode. The result is registered,
//   giving a fixed one-cycle latency into writeback and the branch unit.
//
// Ports:
//   i_clk      in   1       clock, rising edge
//   i_rst      in   1       synchronous active-high reset, clears ow_result
//   i_alu_op   in   ALUOPS  operation select
//   i_data_1   in   XLEN    operand A (rs1 / PC)
//   i_data_2   in   XLEN    operand B (rs2 / immediate, shift amount in [4:0])
//   shamt      in   5       reserved, not used by this revision
//   ow_result  out  XLEN    registered result

module rv32i_alu #(
  parameter int XLEN   = 32,
  parameter int ALUOPS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ALUOPS-1:0] i_alu_op,
  input  logic [XLEN-1:0]   i_data_1,
  input  logic [XLEN-1:0]   i_data_2,
  input  logic [4:0]        shamt,
  output logic [XLEN-1:0]   ow_result
);

  localparam logic [ALUOPS-1:0] OP_ADD  = ALUOPS'(0);
  localparam logic [ALUOPS-1:0] OP_SUB  = ALUOPS'(1);
  localparam logic [ALUOPS-1:0] OP_AND  = ALUOPS'(2);
  localparam logic [ALUOPS-1:0] OP_OR   = ALUOPS'(3);
  localparam logic [ALUOPS-1:0] OP_XOR  = ALUOPS'(4);
  localparam logic [ALUOPS-1:0] OP_SLL  = ALUOPS'(5);
  localparam logic [ALUOPS-1:0] OP_SRL  = ALUOPS'(6);
  localparam logic [ALUOPS-1:0] OP_SRA  = ALUOPS'(7);
  localparam logic [ALUOPS-1:0] OP_SLT  = ALUOPS'(8);
  localparam logic [ALUOPS-1:0] OP_SLTU = ALUOPS'(9);
  localparam logic [ALUOPS-1:0] OP_EQ   = ALUOPS'(10);
  localparam logic [ALUOPS-1:0] OP_NEQ  = ALUOPS'(11);
  localparam logic [ALUOPS-1:0] OP_GE   = ALUOPS'(12);
  localparam logic [ALUOPS-1:0] OP_GEU  = ALUOPS'(13);

  logic [XLEN-1:0] result_d;
  logic [XLEN-1:0] result_q;

  // Shift amount always comes from B; decode places the immediate shamt there,
  // so the dedicated shamt port stays unused.
  logic [4:0] sh_amt;
  logic       lt_signed;
  logic       lt_unsigned;
  logic       cmp_bit;
  logic       cmp_sel;
  logic       unused_shamt;

  assign sh_amt       = i_data_2[4:0];
  assign lt_signed    = $signed(i_data_1) < $signed(i_data_2);
  assign lt_unsigned  = i_data_1 < i_data_2;
  assign unused_shamt = ^shamt;

  // Compare ops share one zero-extended output bit.
  always_comb begin
    cmp_bit = 1'b0;
    cmp_sel = 1'b1;
    case (i_alu_op)
      OP_SLT:  cmp_bit = lt_signed;
      OP_SLTU: cmp_bit = lt_unsigned;
      OP_EQ:   cmp_bit = (i_data_1 == i_data_2);
      OP_NEQ:  cmp_bit = (i_data_1 != i_data_2);
      OP_GE:   cmp_bit = ~lt_signed;
      OP_GEU:  cmp_bit = ~lt_unsigned;
      default: cmp_sel = 1'b0;
    endcase
  end

  always_comb begin
    result_d = '0;
    case (i_alu_op)
      OP_ADD:  result_d = i_data_1 + i_data_2;
      OP_SUB:  result_d = i_data_1 - i_data_2;
      OP_AND:  result_d = i_data_1 & i_data_2;
      OP_OR:   result_d = i_data_1 | i_data_2;
      OP_XOR:  result_d = i_data_1 ^ i_data_2;
      OP_SLL:  result_d = i_data_1 << sh_amt;
      OP_SRL:  result_d = i_data_1 >> sh_amt;
      OP_SRA:  result_d = $unsigned($signed(i_data_1) >>> sh_amt);
      default: begin
        // Opcodes 14/15 fall through with cmp_sel low and produce zero.
        if (cmp_sel) begin
          result_d = {{(XLEN-1){1'b0}}, cmp_bit};
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign ow_result = result_q;

endmodule

// File: tb/tb_rv32i_alu.sv
// tb/tb_rv32i_alu.sv - directed self-checking bench for rv32i_alu

module tb_rv32i_alu;

  logic        i_clk;
  logic        i_rst;
  logic [3:0]  i_alu_op;
  logic [31:0] i_data_1;
  logic [31:0] i_data_2;
  logic [4:0]  shamt;
  logic [31:0] ow_result;

  int n_checks = 0;
  int n_fails  = 0;

  rv32i_alu #(.XLEN(32), .ALUOPS(4)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_alu_op  (i_alu_op),
    .i_data_1  (i_data_1),
    .i_data_2  (i_data_2),
    .shamt     (shamt),
    .ow_result (ow_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Apply inputs away from the edge, clock once, sample just after the edge.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    i_alu_op = op;
    i_data_1 = a;
    i_data_2 = b;
    shamt    = 5'(op + 4'd7);
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    drive(4'd0, 32'hDEADBEEF, 32'h12345678);
    n_checks++;
    if (ow_result !== 32'h0) begin
      n_fails++;
      $display("FAIL reset_clear: got %h expected %h", ow_result, 32'h0);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(4'd0, 32'd10, 32'd5);
    n_checks++;
    if (ow_result !== 32'd15) begin
      n_fails++;
      $display("FAIL reset_first_add: got %h expected %h", ow_result, 32'd15);
    end
  endtask

  task automatic test_arith();
    logic [3:0]  op [4]  = '{4'd1, 4'd0, 4'd0, 4'd1};
    logic [31:0] a  [4]  = '{32'd15, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0};
    logic [31:0] b  [4]  = '{32'd20, 32'd1, 32'd1, 32'h1};
    logic [31:0] ex [4]  = '{32'hFFFFFFFB, 32'h0, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      drive(op[i], a[i], b[i]);
      n_checks++;
      if (ow_result !== ex[i]) begin
        n_fails++;
        $display("FAIL arith[%0d]: got %h expected %h", i, ow_result, ex[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [3:0]  op [3] = '{4'd2, 4'd3, 4'd4};
    logic [31:0] a  [3] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hAAAAAAAA};
    logic [31:0] b  [3] = '{32'h0FF00FF0, 32'h0FF00FF0, 32'h55555555};
    logic [31:0] ex [3] = '{32'h00F000F0, 32'hFFF0FFF0, 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      drive(op[i], a[i], b[i]);
      n_checks++;
      if (ow_result !== ex[i]) begin
        n_fails++;
        $display("FAIL logic[%0d]: got %h expected %h", i, ow_result, ex[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [3:0]  op [6] = '{4'd5, 4'd6, 4'd7, 4'd6, 4'd5, 4'd7};
    logic [31:0] a  [6] = '{32'd1, 32'd128, 32'hFFFFFFC0, 32'h80000000, 32'h3, 32'h40000000};
    logic [31:0] b  [6] = '{32'd3, 32'd2, 32'd2, 32'h21, 32'h20, 32'd30};
    logic [31:0] ex [6] = '{32'd8, 32'd32, 32'hFFFFFFF0, 32'h40000000, 32'h3, 32'h1};
    for (int i = 0; i < 6; i++) begin
      drive(op[i], a[i], b[i]);
      n_checks++;
      if (ow_result !== ex[i]) begin
        n_fails++;
        $display("FAIL shift[%0d]: got %h expected %h", i, ow_result, ex[i]);
      end
    end
  endtask

  task automatic test_compare();
    logic [3:0]  op [10] = '{4'd8, 4'd8, 4'd9, 4'd12, 4'd10, 4'd11, 4'd13,
                             4'd8, 4'd9, 4'd12};
    logic [31:0] a  [10] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd10, 32'd100, 32'd10, 32'd5,
                             32'h80000000, 32'h80000000, 32'h80000000};
    logic [31:0] b  [10] = '{32'd10, 32'd0, 32'd0, 32'd5, 32'd100, 32'd20, 32'd10,
                             32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    logic [31:0] ex [10] = '{32'd1, 32'd1, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0,
                             32'd1, 32'd0, 32'd0};
    for (int i = 0; i < 10; i++) begin
      drive(op[i], a[i], b[i]);
      n_checks++;
      if (ow_result !== ex[i]) begin
        n_fails++;
        $display("FAIL compare[%0d]: got %h expected %h", i, ow_result, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                             4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd15, 4'd14};
    logic [31:0] a  [16] = '{32'd7, 32'd3, 32'hFF00, 32'd1, 32'hF, 32'd3, 32'hFFFFFFFF, 32'h80000000,
                             32'h80000000, 32'h80000000, 32'd5, 32'd5, 32'hFFFFFFFB, 32'd0,
                             32'd1, 32'hFFFFFFFF};
    logic [31:0] b  [16] = '{32'd8, 32'd5, 32'h0FF0, 32'd2, 32'd5, 32'h20, 32'd28, 32'd31,
                             32'h7FFFFFFF, 32'h7FFFFFFF, 32'd6, 32'd5, 32'hFFFFFFFB, 32'd1,
                             32'd2, 32'hFFFFFFFF};
    logic [31:0] ex [16] = '{32'd15, 32'hFFFFFFFE, 32'h0F00, 32'd3, 32'hA, 32'd3, 32'hF, 32'hFFFFFFFF,
                             32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 16; i++) begin
      @(negedge i_clk);
      // Before the edge the previous op's result must still be held.
      if (i > 0) begin
        n_checks++;
        if (ow_result !== ex[i-1]) begin
          n_fails++;
          $display("FAIL b2b_hold[%0d]: got %h expected %h", i, ow_result, ex[i-1]);
        end
      end
      i_alu_op = op[i];
      i_data_1 = a[i];
      i_data_2 = b[i];
      @(posedge i_clk);
      #1;
      n_checks++;
      if (ow_result !== ex[i]) begin
        n_fails++;
        $display("FAIL b2b[%0d]: got %h expected %h", i, ow_result, ex[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(4'd0, 32'd1, 32'd2);
    n_checks++;
    if (ow_result !== 32'd3) begin
      n_fails++;
      $display("FAIL mid_pre: got %h expected %h", ow_result, 32'd3);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    drive(4'd0, 32'd4, 32'd4);
    n_checks++;
    if (ow_result !== 32'd0) begin
      n_fails++;
      $display("FAIL mid_reset: got %h expected %h", ow_result, 32'd0);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(4'd0, 32'd4, 32'd4);
    n_checks++;
    if (ow_result !== 32'd8) begin
      n_fails++;
      $display("FAIL mid_release: got %h expected %h", ow_result, 32'd8);
    end
  endtask

  initial begin
    i_rst    = 1'b1;
    i_alu_op = 4'd0;
    i_data_1 = 32'h0;
    i_data_2 = 32'h0;
    shamt    = 5'h0;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_compare();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
